// File: rtl/gas_alarm_pkg.sv
// Shared constants for the gas alarm manager: gas bit positions and level/state encoding.
package gas_alarm_pkg;

  localparam int NUM_GAS = 3;
  localparam int GAS_CH4 = 0;
  localparam int GAS_CO  = 1;
  localparam int GAS_CO2 = 2;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ALERT = 2'd1;
  localparam logic [1:0] ST_ALARM = 2'd2;
  localparam logic [1:0] ST_HOLD  = 2'd3;

endpackage

// File: rtl/gas_event_counter.sv
// Per-gas pending latch and saturating repeat counter; a detect in the same
// cycle as a clear restarts the count at 1.
module gas_event_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             set,
  input  logic             clr,
  output logic             pending,
  output logic [CNT_W-1:0] count
);

  logic             pending_q, pending_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    pending_d = pending_q;
    count_d   = count_q;
    if (set) begin
      pending_d = 1'b1;
      if (clr) begin
        count_d = CNT_W'(1);
      end else if (count_q != '1) begin
        count_d = count_q + CNT_W'(1);
      end
    end else if (clr) begin
      pending_d = 1'b0;
      count_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      pending_q <= 1'b0;
      count_q   <= '0;
    end else begin
      pending_q <= pending_d;
      count_q   <= count_d;
    end
  end

  assign pending = pending_q;
  assign count   = count_q;

endmodule

// File: rtl/gas_alarm_manager.sv
// Alarm manager: per-gas event counters, IDLE/ALERT/ALARM/HOLD FSM and buzzer drive.
// Optional ALERT inactivity auto-clear is enabled by defining GAS_ALARM_AUTOCLR_EN.
module gas_alarm_manager
  import gas_alarm_pkg::*;
#(
  parameter int CNT_W       = 4,
  parameter int ESC_THRESH  = 3,
  parameter int BEEP_HALF   = 4,
  parameter int HOLD_CYC    = 16
`ifdef GAS_ALARM_AUTOCLR_EN
  , parameter int AUTOCLR_CYC = 64
`endif
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic [2:0]       det,
  input  logic             ack,
  input  logic [2:0]       ack_mask,
  output logic [2:0]       pending,
  output logic [1:0]       level,
  output logic             buzzer,
  output logic [CNT_W-1:0] cnt_ch4,
  output logic [CNT_W-1:0] cnt_co,
  output logic [CNT_W-1:0] cnt_co2
);

  localparam int BEEP_W = $clog2(BEEP_HALF + 1);
  localparam int HOLD_W = $clog2(HOLD_CYC + 1);

  logic [NUM_GAS-1:0] clr;
  logic [NUM_GAS-1:0] pend;
  logic [NUM_GAS-1:0] pend_nxt;
  logic [CNT_W-1:0]   cnt     [NUM_GAS];
  logic [CNT_W-1:0]   cnt_nxt [NUM_GAS];
  logic               crit;
  logic               autoclr_fire;

  logic [1:0]        state_q, state_d;
  logic [BEEP_W-1:0] beep_q, beep_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              buzzer_q, buzzer_d;

  for (genvar g = 0; g < NUM_GAS; g++) begin : g_gas
    assign clr[g] = (ack & ack_mask[g]) | autoclr_fire;
    gas_event_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk     (clk),
      .arst_n  (arst_n),
      .set     (det[g]),
      .clr     (clr[g]),
      .pending (pend[g]),
      .count   (cnt[g])
    );
  end

  // The FSM decides on the values the counters will hold after this edge.
  always_comb begin
    pend_nxt = pend;
    crit     = 1'b0;
    for (int i = 0; i < NUM_GAS; i++) begin
      cnt_nxt[i] = cnt[i];
      if (det[i]) begin
        pend_nxt[i] = 1'b1;
        if (clr[i])               cnt_nxt[i] = CNT_W'(1);
        else if (cnt[i] != '1)    cnt_nxt[i] = cnt[i] + CNT_W'(1);
      end else if (clr[i]) begin
        pend_nxt[i] = 1'b0;
        cnt_nxt[i]  = '0;
      end
      if (cnt_nxt[i] >= CNT_W'(ESC_THRESH)) crit = 1'b1;
    end
    if (pend_nxt[GAS_CO]) crit = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (pend_nxt != '0) state_d = crit ? ST_ALARM : ST_ALERT;
      ST_ALERT: if (pend_nxt == '0) state_d = ST_HOLD;
                else if (crit)      state_d = ST_ALARM;
      ST_ALARM: if (pend_nxt == '0) state_d = ST_HOLD;
      default: begin
        if (pend_nxt != '0)                          state_d = crit ? ST_ALARM : ST_ALERT;
        else if (hold_q == HOLD_W'(HOLD_CYC - 1))    state_d = ST_IDLE;
      end
    endcase
  end

  // Beep phase restarts high on every ALERT entry.
  always_comb begin
    hold_d   = (state_q == ST_HOLD && state_d == ST_HOLD) ? hold_q + HOLD_W'(1) : '0;
    beep_d   = '0;
    buzzer_d = 1'b0;
    if (state_d == ST_ALARM) begin
      buzzer_d = 1'b1;
    end else if (state_d == ST_ALERT) begin
      if (state_q != ST_ALERT) begin
        buzzer_d = 1'b1;
      end else if (beep_q == BEEP_W'(BEEP_HALF - 1)) begin
        buzzer_d = ~buzzer_q;
      end else begin
        beep_d   = beep_q + BEEP_W'(1);
        buzzer_d = buzzer_q;
      end
    end
  end

`ifdef GAS_ALARM_AUTOCLR_EN
  localparam int AC_W = $clog2(AUTOCLR_CYC + 1);
  logic [AC_W-1:0] quiet_q, quiet_d;

  assign autoclr_fire = (state_q == ST_ALERT) && (det == 3'b000) &&
                        (quiet_q == AC_W'(AUTOCLR_CYC - 1));

  always_comb begin
    quiet_d = '0;
    if (state_q == ST_ALERT && state_d == ST_ALERT && det == 3'b000) quiet_d = quiet_q + AC_W'(1);
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) quiet_q <= '0;
    else         quiet_q <= quiet_d;
  end
`else
  assign autoclr_fire = 1'b0;
`endif

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q  <= ST_IDLE;
      beep_q   <= '0;
      hold_q   <= '0;
      buzzer_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      beep_q   <= beep_d;
      hold_q   <= hold_d;
      buzzer_q <= buzzer_d;
    end
  end

  assign pending = pend;
  assign level   = state_q;
  assign buzzer  = buzzer_q;
  assign cnt_ch4 = cnt[GAS_CH4];
  assign cnt_co  = cnt[GAS_CO];
  assign cnt_co2 = cnt[GAS_CO2];

endmodule

// File: tb/tb_gas_alarm_manager.sv
// Directed bench for gas_alarm_manager: a behavioural model fills a scoreboard queue
// as stimulus is driven; entries are popped and compared one cycle later.
module tb_gas_alarm_manager;
  import gas_alarm_pkg::*;

  localparam int AUTOCLR = 64;

  logic       clk = 1'b0;
  logic       arst_n = 1'b0;
  logic [2:0] det = '0;
  logic       ack = 1'b0;
  logic [2:0] ack_mask = '0;
  logic [2:0] pending;
  logic [1:0] level;
  logic       buzzer;
  logic [3:0] cntCh4, cntCo, cntCo2;

  typedef struct {
    logic [2:0] pend;
    logic [1:0] lvl;
    logic       buz;
    logic [3:0] c0;
    logic [3:0] c1;
    logic [3:0] c2;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad = 0;

  logic [2:0] mp;
  int         mc [3];
  logic [1:0] mlvl;
  logic       mbuz;
  int         age, hold, quiet;

  always #5 clk = ~clk;

  gas_alarm_manager dut (
    .clk      (clk),
    .arst_n   (arst_n),
    .det      (det),
    .ack      (ack),
    .ack_mask (ack_mask),
    .pending  (pending),
    .level    (level),
    .buzzer   (buzzer),
    .cnt_ch4  (cntCh4),
    .cnt_co   (cntCo),
    .cnt_co2  (cntCo2)
  );

  task automatic checkField(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mp = '0; mc[0] = 0; mc[1] = 0; mc[2] = 0;
    mlvl = ST_IDLE; mbuz = 1'b0; age = 0; hold = 0; quiet = 0;
  endtask

  task automatic modelStep(input logic [2:0] d, input logic a, input logic [2:0] m);
    bit fire, crit;
    logic [1:0] nl;
    fire = 1'b0;
`ifdef GAS_ALARM_AUTOCLR_EN
    if (mlvl == ST_ALERT && d == 3'b000 && quiet + 1 == AUTOCLR) fire = 1'b1;
`endif
    for (int i = 0; i < 3; i++) begin
      bit c;
      c = (a && m[i]) || fire;
      if (d[i]) begin
        mp[i] = 1'b1;
        mc[i] = c ? 1 : ((mc[i] == 15) ? 15 : mc[i] + 1);
      end else if (c) begin
        mp[i] = 1'b0;
        mc[i] = 0;
      end
    end
    crit = mp[1] || mc[0] >= 3 || mc[1] >= 3 || mc[2] >= 3;
    case (mlvl)
      ST_IDLE:  nl = (mp == 0) ? ST_IDLE : (crit ? ST_ALARM : ST_ALERT);
      ST_ALERT: nl = (mp == 0) ? ST_HOLD : (crit ? ST_ALARM : ST_ALERT);
      ST_ALARM: nl = (mp == 0) ? ST_HOLD : ST_ALARM;
      default:  nl = (mp != 0) ? (crit ? ST_ALARM : ST_ALERT) : ((hold + 1 == 16) ? ST_IDLE : ST_HOLD);
    endcase
    hold  = (nl == ST_HOLD && mlvl == ST_HOLD) ? hold + 1 : 0;
    age   = (nl == ST_ALERT && mlvl == ST_ALERT) ? age + 1 : 0;
    quiet = (nl == ST_ALERT && mlvl == ST_ALERT && d == 3'b000) ? quiet + 1 : 0;
    mbuz  = (nl == ST_ALARM) ? 1'b1 : (nl == ST_ALERT) ? ((age / 4) % 2 == 0) : 1'b0;
    mlvl  = nl;
  endtask

  task automatic applyStimulus(input logic [2:0] d, input logic a, input logic [2:0] m);
    exp_t e;
    det = d; ack = a; ack_mask = m;
    modelStep(d, a, m);
    e.pend = mp; e.lvl = mlvl; e.buz = mbuz;
    e.c0 = mc[0][3:0]; e.c1 = mc[1][3:0]; e.c2 = mc[2][3:0];
    sbq.push_back(e);
    @(posedge clk);
    #1;
    det = '0; ack = 1'b0; ack_mask = '0;
  endtask

  task automatic checkOutput(input string tag);
    exp_t e;
    if (sbq.size() == 0) begin
      total++;
      bad++;
      $error("[TB] FAIL %s observed=empty_queue expected=entry", tag);
    end else begin
      e = sbq.pop_front();
      checkField({tag, ".pending"}, pending, e.pend);
      checkField({tag, ".level"},   level,   e.lvl);
      checkField({tag, ".buzzer"},  buzzer,  e.buz);
      checkField({tag, ".cnt_ch4"}, cntCh4,  e.c0);
      checkField({tag, ".cnt_co"},  cntCo,   e.c1);
      checkField({tag, ".cnt_co2"}, cntCo2,  e.c2);
    end
  endtask

  task automatic step(input logic [2:0] d, input logic a, input logic [2:0] m, input string tag);
    applyStimulus(d, a, m);
    checkOutput(tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int k = 0; k < n; k++) step(3'b000, 1'b0, 3'b000, tag);
  endtask

  task automatic checkAllZero(input string tag);
    checkField({tag, ".pending"}, pending, 0);
    checkField({tag, ".level"},   level,   0);
    checkField({tag, ".buzzer"},  buzzer,  0);
    checkField({tag, ".cnt_ch4"}, cntCh4,  0);
    checkField({tag, ".cnt_co"},  cntCo,   0);
    checkField({tag, ".cnt_co2"}, cntCo2,  0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    modelReset();
    #3;
    checkAllZero("reset");
    @(negedge clk);
    arst_n = 1'b1;

    // CH4 alert with 4-high/4-low beep, then full ack and hold back to idle
    step(3'b001, 1'b0, 3'b000, "t1_ch4");
    checkField("t1_level_alert", level, ST_ALERT);
    idle(3, "t1_beep_hi");
    checkField("t1_buz_hi", buzzer, 1);
    idle(4, "t1_beep_lo");
    checkField("t1_buz_lo", buzzer, 0);
    idle(1, "t1_beep_hi2");
    step(3'b000, 1'b1, 3'b001, "t1_ack");
    idle(16, "t1_hold");
    checkField("t1_back_idle", level, ST_IDLE);

    // CO goes straight to ALARM
    step(3'b010, 1'b0, 3'b000, "t2_co");
    checkField("t2_alarm", level, ST_ALARM);
    checkField("t2_buz", buzzer, 1);
    idle(3, "t2_alarm_stay");
    step(3'b000, 1'b1, 3'b010, "t2_ack");
    checkField("t2_hold", level, ST_HOLD);
    idle(15, "t2_hold_run");
    checkField("t2_hold_last", level, ST_HOLD);
    idle(1, "t2_hold_exit");
    checkField("t2_idle", level, ST_IDLE);

    // CO2 repeats escalate on the third, then saturate
    for (int k = 0; k < 3; k++) step(3'b100, 1'b0, 3'b000, "t3_co2");
    checkField("t3_escalate", level, ST_ALARM);
    for (int k = 0; k < 20; k++) step(3'b100, 1'b0, 3'b000, "t3_sat");
    checkField("t3_cnt15", cntCo2, 15);
    step(3'b000, 1'b1, 3'b100, "t3_ack");
    idle(16, "t3_hold");

    // Partial ack, then same-edge det and ack on CO2
    step(3'b101, 1'b0, 3'b000, "t4_both");
    step(3'b100, 1'b0, 3'b000, "t4_co2_again");
    step(3'b000, 1'b1, 3'b001, "t4_partial");
    checkField("t4_pend100", pending, 3'b100);
    checkField("t4_still_alert", level, ST_ALERT);
    step(3'b100, 1'b1, 3'b100, "t4_set_wins");
    checkField("t4_cnt1", cntCo2, 1);
    checkField("t4_no_hold", level, ST_ALERT);
    step(3'b000, 1'b1, 3'b000, "t4_mask0");
    step(3'b000, 1'b1, 3'b100, "t4_full_ack");

    // Re-detect mid-hold, then async reset during ALARM
    idle(4, "t5_hold");
    step(3'b001, 1'b0, 3'b000, "t5_redetect");
    checkField("t5_alert", level, ST_ALERT);
    step(3'b010, 1'b0, 3'b000, "t5_co");
    #2;
    arst_n = 1'b0;
    #1;
    checkAllZero("t5_async_rst");
    modelReset();
    @(negedge clk);
    arst_n = 1'b1;
    step(3'b000, 1'b1, 3'b111, "t5_ack_idle");

    step(3'b001, 1'b0, 3'b000, "t6_ch4");
`ifdef GAS_ALARM_AUTOCLR_EN
    idle(AUTOCLR - 1, "t6_quiet");
    checkField("t6_pre_clear", level, ST_ALERT);
    idle(1, "t6_autoclr");
    checkField("t6_pend0", pending, 0);
    checkField("t6_hold", level, ST_HOLD);
`else
    idle(210, "t6_persist");
    checkField("t6_alert", level, ST_ALERT);
    checkField("t6_pend", pending, 3'b001);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
